// File: rtl/mem_pkg.sv
// Shared sizing and helpers for the cache backing store.
package mem_pkg;

  localparam int MEM_ADDR_BITS = 10;
  localparam int DATA_WIDTH    = 8;
  localparam int BLOCK_BYTES   = 8;

  function automatic logic mem_in_range(
    input logic [31:0] addr,
    input int unsigned bits = MEM_ADDR_BITS
  );
    return (addr >> bits) == 32'd0;
  endfunction

endpackage

// File: rtl/main_memory.sv
// Byte-addressable backing store: combinational read, clocked write,
// async reset loads each byte with its own low address bits.
module main_memory
  import mem_pkg::*;
#(
  parameter int MEM_ADDR_BITS = mem_pkg::MEM_ADDR_BITS,
  parameter int DATA_WIDTH    = mem_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           Address,
  input  logic [DATA_WIDTH-1:0] Data,
  input  logic                  ismemWrite,
  output logic [DATA_WIDTH-1:0] outputmem
);

  localparam int DEPTH = 1 << MEM_ADDR_BITS;

  logic [DATA_WIDTH-1:0]    r_mem [DEPTH];
  logic [MEM_ADDR_BITS-1:0] w_idx;
  logic                     w_in_range;

  assign w_idx      = Address[MEM_ADDR_BITS-1:0];
  assign w_in_range = mem_in_range(Address, MEM_ADDR_BITS);

  // Flop array: per-word async reset pattern precludes a RAM macro
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= DATA_WIDTH'(i);
      end
    end else if (ismemWrite && w_in_range) begin
      r_mem[w_idx] <= Data;
    end
  end

  assign outputmem = w_in_range ? r_mem[w_idx] : '0;

endmodule

// File: tb/tb_main_memory.sv
// Directed bench for main_memory: reset pattern, writes, range, async reset.
module tb_main_memory;

  logic        clk;
  logic        rst_n;
  logic [31:0] Address;
  logic [7:0]  Data;
  logic        ismemWrite;
  logic [7:0]  outputmem;

  int n_vec;
  int n_bad;

  main_memory dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Address    (Address),
    .Data       (Data),
    .ismemWrite (ismemWrite),
    .outputmem  (outputmem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] a,
                    input logic [7:0] exp);
    Address = a;
    #1;
    check(tag, outputmem, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    @(negedge clk);
    Address    = a;
    Data       = d;
    ismemWrite = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    ismemWrite = 1'b0;
  endtask

  initial begin
    n_vec      = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    Address    = 32'd0;
    Data       = 8'd0;
    ismemWrite = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    rd("rst_40",   32'd40,   8'd40);
    rd("rst_300",  32'd300,  8'd44);
    rd("rst_1023", 32'd1023, 8'hFF);

    wr(32'd40, 8'h04);
    rd("wr_40",   32'd40, 8'h04);
    rd("wr_41",   32'd41, 8'd41);

    @(negedge clk);
    Address    = 32'd5;
    Data       = 8'hAA;
    ismemWrite = 1'b1;
    #1;
    check("rdw_pre", outputmem, 8'h05);
    @(posedge clk);
    #1;
    check("rdw_post", outputmem, 8'hAA);
    @(negedge clk);
    ismemWrite = 1'b0;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      Address    = 32'd32 + 32'(i);
      Data       = 8'hC0 + 8'(i);
      ismemWrite = 1'b1;
    end
    @(negedge clk);
    ismemWrite = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd($sformatf("blk_%0d", 32 + i), 32'd32 + 32'(i), 8'hC0 + 8'(i));
    end
    rd("blk_40", 32'd40, 8'h04);

    wr(32'h0000_0400, 8'h55);
    rd("oor_400",  32'h0000_0400, 8'h00);
    rd("oor_alias", 32'd0, 8'h00);
    rd("oor_hi",   32'h8000_0028, 8'h00);

    wr(32'd3, 8'h77);
    rd("pre_rst_3", 32'd3, 8'h77);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_3", outputmem, 8'h03);
    rd("arst_40", 32'd40, 8'd40);
    rd("arst_32", 32'd32, 8'd32);
    rd("arst_5",  32'd5,  8'd5);
    @(negedge clk);
    Address    = 32'd3;
    Data       = 8'h99;
    ismemWrite = 1'b1;
    @(posedge clk);
    #1;
    check("rstlow_wr", outputmem, 8'h03);
    @(negedge clk);
    ismemWrite = 1'b0;
    rst_n      = 1'b1;
    rd("post_rel_3", 32'd3, 8'h03);

    wr(32'd1023, 8'h5A);
    rd("wr_1023", 32'd1023, 8'h5A);
    rd("wr_1022", 32'd1022, 8'hFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
